shifter_arbiter: RTL and testbench

- Shares one 16-bit barrel shifter datapath (SLL/SRA/ROR) between two requesters, e.g. the ALU shift path and a second issuing unit.
- Round-robin arbitration at the request side; valid/ready handshakes on both request and response.
- Registered per-requester response slots with backpressure; one shift issued per cycle.

---
 rtl/shifter_arbiter.sv | 125 ++++++++++++
 tb/tb_shifter_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/shifter_arbiter.sv
// Two requesters share one 16-bit barrel shifter (SLL/SRA/ROR).
// Round-robin grant at the request side, registered response slot per requester.

module shifter_arbiter_slot (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] result,
  input  logic        rsp_ready,
  output logic        rsp_valid,
  output logic [15:0] rsp_data,
  output logic        slot_free
);
  // A full slot can take a new result in the same cycle it drains.
  assign slot_free = !rsp_valid | rsp_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_data  <= 16'h0000;
    end else if (load) begin
      rsp_valid <= 1'b1;
      rsp_data  <= result;
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end
endmodule

module shifter_arbiter #(
  parameter bit PRIORITY_INIT = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [15:0] req0_data,
  input  logic [3:0]  req0_amt,
  input  logic [1:0]  req0_mode,
  output logic        rsp0_valid,
  output logic [15:0] rsp0_data,
  input  logic        rsp0_ready,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [15:0] req1_data,
  input  logic [3:0]  req1_amt,
  input  logic [1:0]  req1_mode,
  output logic        rsp1_valid,
  output logic [15:0] rsp1_data,
  input  logic        rsp1_ready
);
  localparam int NUM_LANES = 2;

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  amt;
    logic [1:0]  mode;
  } shift_req_t;

  shift_req_t [NUM_LANES-1:0]       req;
  shift_req_t                       sel;
  logic [NUM_LANES-1:0]             req_valid, rsp_ready, rsp_valid, slot_free, elig, grant;
  logic [NUM_LANES-1:0][15:0]       rsp_data;
  logic [15:0]                      result;
  logic                             ptr;

  assign req       = {shift_req_t'({req1_data, req1_amt, req1_mode}),
                      shift_req_t'({req0_data, req0_amt, req0_mode})};
  assign req_valid = {req1_valid, req0_valid};
  assign rsp_ready = {rsp1_ready, rsp0_ready};
  assign elig      = req_valid & slot_free;

  always_comb begin
    grant = '0;
    if (!rst) begin
      if (&elig) grant = ptr ? 2'b10 : 2'b01;
      else       grant = elig;
    end
  end

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  // With no grant the mux parks on requester 0; the result is then unused.
  assign sel = grant[1] ? req[1] : req[0];

  function automatic logic [15:0] shift16(input logic [15:0] d, input logic [3:0] a,
                                          input logic [1:0] m);
    logic [31:0] rot;
    logic [15:0] r;
    rot = {d, d} >> a;
    case (m)
      2'b01:   r = 16'($signed(d) >>> a);
      2'b11:   r = rot[15:0];
      default: r = d << a;
    endcase
    return r;
  endfunction

  assign result = shift16(sel.data, sel.amt, sel.mode);

  always_ff @(posedge clk) begin
    if (rst)           ptr <= PRIORITY_INIT;
    else if (grant[0]) ptr <= 1'b1;
    else if (grant[1]) ptr <= 1'b0;
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_slot
    shifter_arbiter_slot u_slot (
      .clk       (clk),
      .rst       (rst),
      .load      (grant[i]),
      .result    (result),
      .rsp_ready (rsp_ready[i]),
      .rsp_valid (rsp_valid[i]),
      .rsp_data  (rsp_data[i]),
      .slot_free (slot_free[i])
    );
  end

  assign rsp0_valid = rsp_valid[0];
  assign rsp1_valid = rsp_valid[1];
  assign rsp0_data  = rsp_data[0];
  assign rsp1_data  = rsp_data[1];
endmodule

// File: tb/tb_shifter_arbiter.sv
// Bench for shifter_arbiter: shift vector table, directed arbitration/backpressure/reset
// sequences, then randomized traffic against a behavioural model.

module tb_shifter_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]       rv, rr;
  logic [1:0][15:0] rd;
  logic [1:0][3:0]  ra;
  logic [1:0][1:0]  rm;
  logic             rdy0, rdy1, sv0, sv1;
  logic [15:0]      sd0, sd1;
  logic [1:0]       rdy;
  assign rdy = {rdy1, rdy0};

  shifter_arbiter #(.PRIORITY_INIT(1'b0)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(rv[0]), .req0_ready(rdy0), .req0_data(rd[0]), .req0_amt(ra[0]), .req0_mode(rm[0]),
    .rsp0_valid(sv0), .rsp0_data(sd0), .rsp0_ready(rr[0]),
    .req1_valid(rv[1]), .req1_ready(rdy1), .req1_data(rd[1]), .req1_amt(ra[1]), .req1_mode(rm[1]),
    .rsp1_valid(sv1), .rsp1_data(sd1), .rsp1_ready(rr[1])
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One bit position per step, amt times: a reference independent of barrel shifting.
  function automatic logic [15:0] ref_shift(input logic [1:0] m, input logic [15:0] d,
                                            input logic [3:0] a);
    logic [15:0] r;
    r = d;
    for (int i = 0; i < int'(a); i++) begin
      case (m)
        2'b01:   r = {r[15], r[15:1]};
        2'b11:   r = {r[0], r[15:1]};
        default: r = {r[14:0], 1'b0};
      endcase
    end
    return r;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; rv = '0; rr = '0;
    cyc(); cyc();
    rst = 1'b0;
  endtask

  task automatic set_req(input int x, input logic [1:0] m, input logic [15:0] d,
                         input logic [3:0] a);
    rv[x] = 1'b1; rm[x] = m; rd[x] = d; ra[x] = a;
  endtask

  typedef struct {
    logic [1:0]  mode;
    logic [15:0] data;
    logic [3:0]  amt;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl[13];

  // Random-phase model state
  logic [1:0]       m_v;
  logic [1:0][15:0] m_d;
  int               m_ptr;

  initial begin
    tbl[0]  = '{2'b00, 16'h0001, 4'd4,  16'h0010};
    tbl[1]  = '{2'b01, 16'h8000, 4'd3,  16'hF000};
    tbl[2]  = '{2'b11, 16'h0001, 4'd1,  16'h8000};
    tbl[3]  = '{2'b11, 16'hA5C3, 4'd0,  16'hA5C3};
    tbl[4]  = '{2'b11, 16'h8001, 4'd15, 16'h0003};
    tbl[5]  = '{2'b10, 16'h0003, 4'd1,  16'h0006};
    tbl[6]  = '{2'b00, 16'h00FF, 4'd8,  16'hFF00};
    tbl[7]  = '{2'b01, 16'h7000, 4'd15, 16'h0000};
    tbl[8]  = '{2'b01, 16'hFFFF, 4'd15, 16'hFFFF};
    tbl[9]  = '{2'b00, 16'h8001, 4'd0,  16'h8001};
    tbl[10] = '{2'b01, 16'h1234, 4'd0,  16'h1234};
    tbl[11] = '{2'b11, 16'h1234, 4'd4,  16'h4123};
    tbl[12] = '{2'b00, 16'h1235, 4'd15, 16'h8000};

    rd = '0; ra = '0; rm = '0;
    rst = 1'b1; rv = 2'b11; rr = '0;
    cyc(); cyc();
    chk("rst_ready", 16'(rdy), 16'h0);
    chk("rst_rsp_valid", 16'({sv1, sv0}), 16'h0);
    chk("rst_rsp0_data", sd0, 16'h0000);
    chk("rst_rsp1_data", sd1, 16'h0000);
    rv = '0;
    rst = 1'b0;

    // Single request: accepted in cycle 0, result in cycle 1, slot empty in cycle 2
    rr = 2'b11;
    set_req(0, 2'b00, 16'h0001, 4'd4);
    #1 chk("s1_ready", 16'(rdy), 16'h1);
    cyc(); rv = '0;
    chk("s1_valid", 16'(sv0), 16'h1);
    chk("s1_data", sd0, 16'h0010);
    cyc();
    chk("s1_drained", 16'(sv0), 16'h0);

    // Vector table through requester 1 and 0 alternately
    for (int i = 0; i < 13; i++) begin
      int x;
      x = i % 2;
      set_req(x, tbl[i].mode, tbl[i].data, tbl[i].amt);
      #1 chk($sformatf("vec%0d_ready", i), 16'(rdy), 16'(1 << x));
      cyc(); rv = '0;
      chk($sformatf("vec%0d_data", i), x ? sd1 : sd0, tbl[i].exp);
    end

    // Tie after reset goes to requester 0, then to 1
    do_reset();
    rr = 2'b11;
    set_req(0, 2'b01, 16'h8000, 4'd3);
    set_req(1, 2'b11, 16'h0001, 4'd1);
    #1 chk("tie_c0", 16'(rdy), 16'h1);
    cyc(); rv[0] = 1'b0;
    #1 chk("tie_c1", 16'(rdy), 16'h2);
    chk("tie_rsp0", sd0, 16'hF000);
    cyc(); rv = '0;
    chk("tie_rsp1", sd1, 16'h8000);

    // Continuous contention: strict alternation, no idle cycle
    begin
      int n0, n1;
      n0 = 0; n1 = 0;
      set_req(0, 2'b00, 16'h0003, 4'd2);
      set_req(1, 2'b01, 16'h8004, 4'd2);
      for (int i = 0; i < 8; i++) begin
        #1 chk($sformatf("alt%0d", i), 16'(rdy), (i % 2) ? 16'h2 : 16'h1);
        n0 += int'(rdy0); n1 += int'(rdy1);
        cyc();
        if (i % 2) chk($sformatf("alt%0d_rsp1", i), sd1, 16'hE001);
        else       chk($sformatf("alt%0d_rsp0", i), sd0, 16'h000C);
      end
      rv = '0;
      chk("alt_n0", 16'(n0), 16'd4);
      chk("alt_n1", 16'(n1), 16'd4);
    end

    // Backpressure on slot 0 does not block requester 1
    do_reset();
    rr = 2'b00;
    set_req(0, 2'b00, 16'h0005, 4'd1);
    #1 cyc(); rv = '0;
    set_req(0, 2'b00, 16'h00FF, 4'd8);
    set_req(1, 2'b01, 16'h7000, 4'd15);
    rr = 2'b10;
    for (int i = 0; i < 3; i++) begin
      #1 chk($sformatf("bp%0d_rdy0", i), 16'(rdy0), 16'h0);
      if (i == 0) chk("bp_rdy1", 16'(rdy1), 16'h1);
      cyc();
      if (i == 0) begin
        rv[1] = 1'b0;
        chk("bp_rsp1_valid", 16'(sv1), 16'h1);
        chk("bp_rsp1_data", sd1, 16'h0000);
      end
      chk($sformatf("bp%0d_rsp0_hold", i), sd0, 16'h000A);
      chk($sformatf("bp%0d_rsp0_valid", i), 16'(sv0), 16'h1);
    end
    rr[0] = 1'b1;
    #1 chk("bp_release", 16'(rdy), 16'h1);
    cyc(); rv = '0;
    chk("bp_rsp0_new", sd0, 16'hFF00);

    // Reset while both slots are held and requests pending
    cyc();
    rr = 2'b00;
    set_req(0, 2'b00, 16'h0011, 4'd1);
    #1 cyc(); rv = '0;
    set_req(1, 2'b00, 16'h0022, 4'd1);
    #1 cyc();
    set_req(0, 2'b00, 16'h0001, 4'd1);
    set_req(1, 2'b00, 16'h0001, 4'd1);
    #1 chk("mid_full_noready", 16'(rdy), 16'h0);
    rst = 1'b1;
    #1 chk("mid_rst_noready", 16'(rdy), 16'h0);
    cyc();
    chk("mid_rst_valid", 16'({sv1, sv0}), 16'h0);
    chk("mid_rst_data0", sd0, 16'h0000);
    chk("mid_rst_data1", sd1, 16'h0000);
    rst = 1'b0; rr = 2'b11;
    #1 chk("mid_post_tie", 16'(rdy), 16'h1);
    cyc(); rv = '0;

    // Randomized traffic against the model
    do_reset();
    m_v = '0; m_d = '0; m_ptr = 0;
    for (int c = 0; c < 600; c++) begin
      logic [1:0] el;
      int w;
      for (int x = 0; x < 2; x++)
        if (!rv[x] && $urandom_range(0, 2) != 0)
          set_req(x, 2'($urandom), 16'($urandom), 4'($urandom));
      rr = 2'($urandom);
      #1;
      for (int x = 0; x < 2; x++) el[x] = rv[x] && (!m_v[x] || rr[x]);
      w = -1;
      if (el == 2'b11) w = m_ptr;
      else if (el[0])  w = 0;
      else if (el[1])  w = 1;
      chk($sformatf("rnd%0d_ready", c), 16'(rdy), (w < 0) ? 16'h0 : 16'(1 << w));
      cyc();
      for (int x = 0; x < 2; x++) begin
        if (w == x) begin
          m_v[x] = 1'b1;
          m_d[x] = ref_shift(rm[x], rd[x], ra[x]);
          rv[x]  = 1'b0;
        end else if (m_v[x] && rr[x]) begin
          m_v[x] = 1'b0;
        end
      end
      if (w >= 0) m_ptr = 1 - w;
      chk($sformatf("rnd%0d_valid", c), 16'({sv1, sv0}), 16'(m_v));
      chk($sformatf("rnd%0d_data0", c), sd0, m_d[0]);
      chk($sformatf("rnd%0d_data1", c), sd1, m_d[1]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
